// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage load/store controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } memop_t;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_RESP = 1'b1
  } mc_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks the addressed byte/half out of a
// little-endian memory word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_ctrl_pkg::*;
(
  input  memop_t      op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

  // Extend the selected field according to the load flavour.
  always_comb begin
    data_o = word_i;
    unique case (op_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'h000000, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     data_o = {16'h0000, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// MEM-stage load/store controller: builds word address, lane mask and
// lane-replicated store data, and returns extended load data one cycle
// after the request while stalling the pipeline for that cycle.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses are
// suppressed and flagged on AddrError instead of silently truncated.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [2:0]           MemOp,
  input  logic [ADDR_BITS-1:0] Address,
  input  logic [WIDTH-1:0]     StoreData,
  output logic [ADDR_BITS-1:0] MemAddress,
  output logic [WIDTH-1:0]     MemWriteData,
  output logic                 MemWriteEnable,
  output logic                 MemReadEnable,
  output logic [3:0]           ByteEnable,
  input  logic [WIDTH-1:0]     MemReadData,
  output logic [WIDTH-1:0]     LoadData,
  output logic                 LoadValid,
  output logic                 Stall,
  output logic                 AddrError
);

  mc_state_t        state_q, state_d;
  logic [WIDTH-1:0] load_data_q;
  logic [WIDTH-1:0] aligned;
  logic             capture;
  logic             misalign;
  memop_t           op, ld_op, st_op;
  logic [1:0]       lane;

  assign op   = memop_t'(MemOp);
  assign lane = Address[1:0];

  // Store encodings on a load, or load encodings on a store, fall back to word size.
  assign ld_op = (op inside {SB, SH, SW}) ? LW : op;
  assign st_op = (op inside {SB, SH}) ? op : SW;

  assign MemAddress = {Address[ADDR_BITS-1:2], 2'b00};
  assign LoadData   = load_data_q;
  assign LoadValid  = (state_q == LOAD_RESP);

`ifdef MEM_ALIGN_CHECK_EN
  logic ld_mis, st_mis;
  // Flag half accesses on odd bytes and word accesses off a word boundary.
  always_comb begin
    ld_mis   = ((ld_op == LH) || (ld_op == LHU)) ? Address[0] :
               (ld_op == LW) ? (lane != 2'b00) : 1'b0;
    st_mis   = (st_op == SH) ? Address[0] :
               (st_op == SW) ? (lane != 2'b00) : 1'b0;
    misalign = (state_q == IDLE) &&
               ((MemRead && ld_mis) || (!MemRead && MemWrite && st_mis));
  end
  assign AddrError = misalign & ~RST;
`else
  assign misalign  = 1'b0;
  assign AddrError = 1'b0;
`endif

  load_align u_load_align (
    .op_i   (ld_op),
    .lane_i (lane),
    .word_i (MemReadData),
    .data_o (aligned)
  );

  // Next-state and memory-side strobes; a load wins over a simultaneous store.
  always_comb begin
    state_d        = state_q;
    MemReadEnable  = 1'b0;
    MemWriteEnable = 1'b0;
    Stall          = 1'b0;
    ByteEnable     = 4'b0000;
    MemWriteData   = '0;
    capture        = 1'b0;
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          if (MemRead && !misalign) begin
            MemReadEnable = 1'b1;
            Stall         = 1'b1;
            ByteEnable    = BE_WORD;
            capture       = 1'b1;
            state_d       = LOAD_RESP;
          end else if (MemWrite && !MemRead && !misalign) begin
            MemWriteEnable = 1'b1;
            unique case (st_op)
              SB: begin
                ByteEnable   = BE_BYTE << lane;
                MemWriteData = {4{StoreData[7:0]}};
              end
              SH: begin
                ByteEnable   = BE_HALF << {lane[1], 1'b0};
                MemWriteData = {2{StoreData[15:0]}};
              end
              default: begin
                ByteEnable   = BE_WORD;
                MemWriteData = StoreData;
              end
            endcase
          end
        end
        LOAD_RESP: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // State register; reset drops any in-flight load.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Load result register, written in the request cycle.
  always_ff @(posedge CLK) begin
    if (RST)          load_data_q <= '0;
    else if (capture) load_data_q <= aligned;
  end

endmodule
